wb_cmd_sequencer: RTL and testbench
===================================

WB_CMD_SEQUENCER -- requirements
Module: wb_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT, 1023: maximum cycles from request acceptance to ack/err before abort.
REQ-002 Parameter ADDR_INC, 1: value added to the address register on auto-increment.
REQ-003 clk  in  1  clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_cmd_valid  in  1  command word present.
REQ-006 o_cmd_ready  out  1  sequencer accepts command this cycle.
REQ-007 i_cmd_data  in  34  [33:32] opcode (0 read, 1 write, 2 set address, 3 special), [31:0] payload.
REQ-008 o_rsp_valid  out  1  response word present.
REQ-009 i_rsp_ready  in  1  consumer accepts response.
REQ-010 o_rsp_data  out  34  [33:32] response code, [31:0] payload.
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined-mode controls.
REQ-012 o_wb_addr  out  32  word address; o_wb_data  out  32  write data; o_wb_sel  out  4  byte selects.
REQ-013 i_wb_stall, i_wb_ack, i_wb_err  in  1 each  slave status; i_wb_data  in  32  read data.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQ, WAIT, RSP.
REQ-015 o_cmd_ready SHALL be 1 only in IDLE; a command is taken when i_cmd_valid & o_cmd_ready.
REQ-016 Opcode 2 SHALL load the address register with payload and go to RSP with code 2, payload = new address.
REQ-017 Opcode 3 SHALL set autoinc = payload[0]; payload[1]=1 SHALL clear the address register to 0; then RSP with code 3, payload = {30'b0, payload[1], autoinc}.
REQ-018 Opcode 0/1 SHALL go to REQ the next cycle with o_wb_cyc=o_wb_stb=1, o_wb_we = opcode[0], o_wb_addr = address register, o_wb_data = payload (write) or 0 (read), o_wb_sel = 4'hF.
REQ-019 In REQ, stb SHALL hold with stable addr/data/we while i_wb_stall=1; on the first cycle with i_wb_stall=0 the FSM SHALL go to WAIT with stb=0 and cyc=1.
REQ-020 i_wb_ack/i_wb_err SHALL be ignored in REQ; they are honoured only in WAIT.
REQ-021 In WAIT, i_wb_ack=1 SHALL drop cyc, go to RSP with code 0 and payload = i_wb_data (read) or code 1 and payload = written data (write).
REQ-022 In WAIT, i_wb_err=1 SHALL drop cyc and go to RSP with code 3, payload = failing address; err wins if ack and err are asserted together.
REQ-023 A timeout counter SHALL clear on command acceptance and increment every cycle in REQ and WAIT; reaching TIMEOUT SHALL drop cyc/stb and go to RSP with code 3, payload = failing address.
REQ-024 After an ack (not err/timeout) with autoinc=1, the address register SHALL increase by ADDR_INC, modulo 2^32 (0xFFFFFFFF wraps to 0x00000000).
REQ-025 In RSP, o_rsp_valid SHALL be 1 with stable o_rsp_data until i_rsp_ready=1, then go to IDLE the next cycle; no new command SHALL be accepted while the response is held.
REQ-026 Exactly one response SHALL be produced per accepted command, in command order.
REQ-027 Minimum latency for a read with no stall and ack on the first WAIT cycle SHALL be 3 cycles from command acceptance to o_rsp_valid.

Reset
REQ-028 While rst=1: FSM in IDLE, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_addr=o_wb_data=0, o_wb_sel=0, o_rsp_valid=0, o_rsp_data=0, o_cmd_ready=0, address=0, autoinc=0, timeout counter=0.
REQ-029 rst asserted mid-transaction SHALL drop cyc/stb on the next edge and discard any pending response.
REQ-030 o_cmd_ready SHALL return to 1 in the first cycle after rst deasserts.

Verification
REQ-031 Set address 0x100, then write 0xDEADBEEF, no stall, ack in cycle 1 of WAIT -> WB write to 0x100 with data 0xDEADBEEF; response {1, 0xDEADBEEF}.
REQ-032 Special payload 1, then set address 0x10, then 3 reads -> addresses 0x10, 0x11, 0x12; responses with code 0 carrying slave data.
REQ-033 Read with i_wb_stall=1 for 5 cycles -> stb held for 6 cycles with stable addr; a single response after ack.
REQ-034 Read with no ack, TIMEOUT=16 -> cyc drops 16 cycles after acceptance; response {3, address}; address not incremented.
REQ-035 Set address 0xFFFFFFFF with autoinc=1, read acked -> address becomes 0x00000000; ack and err together -> error response.
REQ-036 i_rsp_ready=0 for 10 cycles -> o_rsp_valid and data held, o_cmd_ready=0; rst pulse during WAIT -> cyc=0 next cycle, no response.

Source files
------------

// File: rtl/wb_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// wb_cmd_sequencer_if
//
// Bundles the three handshakes of the command sequencer:
//   command stream  : i_cmd_valid / o_cmd_ready / i_cmd_data[33:0]
//   response stream : o_rsp_valid / i_rsp_ready / o_rsp_data[33:0]
//   Wishbone (pipelined) master port:
//     o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr[31:0], o_wb_data[31:0],
//     o_wb_sel[3:0], i_wb_stall, i_wb_ack, i_wb_err, i_wb_data[31:0]
//
// Signal prefixes are from the sequencer's point of view.
// Modports:
//   master - the sequencer itself (drives every o_* signal)
//   slave  - the environment: command source, response sink and Wishbone slave
// ---------------------------------------------------------------------------
interface wb_cmd_sequencer_if;
  // Command stream
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [33:0] i_cmd_data;

  // Response stream
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [33:0] o_rsp_data;

  // Wishbone master
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_data;

  modport master (
    input  i_cmd_valid, i_cmd_data, i_rsp_ready,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
    output o_cmd_ready, o_rsp_valid, o_rsp_data,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );

  modport slave (
    output i_cmd_valid, i_cmd_data, i_rsp_ready,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );
endinterface

// File: rtl/wb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// wb_cmd_sequencer
//
// Turns a stream of 34-bit command words into single Wishbone pipelined-mode
// transfers and returns exactly one 34-bit response word per command, in
// command order.
//
// Command word : [33:32] opcode, [31:0] payload
//   0 read      : read from the address register
//   1 write     : write payload to the address register
//   2 set addr  : address register <= payload
//   3 special   : autoinc <= payload[0]; payload[1] clears the address register
// Response word: [33:32] code, [31:0] payload
//   0 read data, 1 written data, 2 new address,
//   3 special status / bus error / timeout (payload = failing address)
//
// Parameters:
//   TIMEOUT  - cycles from command acceptance until an unanswered bus cycle
//              is aborted
//   ADDR_INC - step added to the address register after an acked transfer
//              while autoinc is set
//
// Ports:
//   clk - clock, rising edge
//   rst - synchronous, active-high reset
//   bus - wb_cmd_sequencer_if.master (command, response and Wishbone signals)
// ---------------------------------------------------------------------------
module wb_cmd_sequencer #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [31:0] ADDR_INC = 32'd1
) (
  input logic              clk,
  input logic              rst,
  wb_cmd_sequencer_if.master bus
);

  // Counter just wide enough to hold TIMEOUT.
  localparam int unsigned    CW      = $clog2(TIMEOUT + 1);
  // The abort fires on the edge where the counter would reach TIMEOUT, so
  // cyc is high for exactly TIMEOUT cycles after acceptance.
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_SETADDR = 2'd2;
  localparam logic [1:0] OP_SPECIAL = 2'd3;

  localparam logic [1:0] RSP_READ    = 2'd0;
  localparam logic [1:0] RSP_WRITE   = 2'd1;
  localparam logic [1:0] RSP_ADDR    = 2'd2;
  localparam logic [1:0] RSP_SPECIAL = 2'd3;  // also used for err / timeout

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t         state_reg;

  // Registered outputs
  logic           cmd_ready_reg;
  logic           rsp_valid_reg;
  logic [33:0]    rsp_data_reg;
  logic           wb_cyc_reg;
  logic           wb_stb_reg;
  logic           wb_we_reg;
  logic [31:0]    wb_addr_reg;
  logic [31:0]    wb_data_reg;
  logic [3:0]     wb_sel_reg;

  // Internal state
  logic [31:0]    addr_reg;
  logic           autoinc_reg;
  logic [CW-1:0]  tcount_reg;

  logic [1:0]     cmd_op;
  logic [31:0]    cmd_payload;
  logic           cmd_fire;
  logic           timeout_hit;

  assign cmd_op      = bus.i_cmd_data[33:32];
  assign cmd_payload = bus.i_cmd_data[31:0];
  assign cmd_fire    = bus.i_cmd_valid & cmd_ready_reg;
  assign timeout_hit = (tcount_reg >= TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      wb_cyc_reg    <= 1'b0;
      wb_stb_reg    <= 1'b0;
      wb_we_reg     <= 1'b0;
      wb_addr_reg   <= '0;
      wb_data_reg   <= '0;
      wb_sel_reg    <= '0;
      addr_reg      <= '0;
      autoinc_reg   <= 1'b0;
      tcount_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Ready is raised here as well so that it comes up on the first
          // cycle after reset without a separate path.
          cmd_ready_reg <= 1'b1;
          if (cmd_fire) begin
            cmd_ready_reg <= 1'b0;
            tcount_reg    <= '0;
            case (cmd_op)
              OP_SETADDR: begin
                addr_reg      <= cmd_payload;
                rsp_data_reg  <= {RSP_ADDR, cmd_payload};
                rsp_valid_reg <= 1'b1;
                state_reg     <= RSP;
              end
              OP_SPECIAL: begin
                autoinc_reg <= cmd_payload[0];
                if (cmd_payload[1]) begin
                  addr_reg <= '0;
                end
                rsp_data_reg  <= {RSP_SPECIAL, 30'd0, cmd_payload[1], cmd_payload[0]};
                rsp_valid_reg <= 1'b1;
                state_reg     <= RSP;
              end
              default: begin
                // OP_READ / OP_WRITE: launch a single pipelined transfer.
                wb_cyc_reg  <= 1'b1;
                wb_stb_reg  <= 1'b1;
                wb_we_reg   <= cmd_op[0];
                wb_addr_reg <= addr_reg;
                wb_data_reg <= (cmd_op == OP_WRITE) ? cmd_payload : 32'd0;
                wb_sel_reg  <= 4'hF;
                state_reg   <= REQ;
              end
            endcase
          end
        end

        REQ: begin
          // Strobe and request fields are frozen while the slave stalls.
          // ack/err are not looked at until the request has been taken.
          tcount_reg <= tcount_reg + 1'b1;
          if (timeout_hit) begin
            wb_cyc_reg    <= 1'b0;
            wb_stb_reg    <= 1'b0;
            wb_we_reg     <= 1'b0;
            rsp_data_reg  <= {RSP_SPECIAL, wb_addr_reg};
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end else if (!bus.i_wb_stall) begin
            wb_stb_reg <= 1'b0;
            state_reg  <= WAIT;
          end
        end

        WAIT: begin
          tcount_reg <= tcount_reg + 1'b1;
          // A slave answer in the same cycle as the timeout still counts;
          // err has priority over ack.
          if (bus.i_wb_err) begin
            wb_cyc_reg    <= 1'b0;
            wb_we_reg     <= 1'b0;
            rsp_data_reg  <= {RSP_SPECIAL, wb_addr_reg};
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end else if (bus.i_wb_ack) begin
            wb_cyc_reg    <= 1'b0;
            wb_we_reg     <= 1'b0;
            rsp_data_reg  <= wb_we_reg ? {RSP_WRITE, wb_data_reg}
                                       : {RSP_READ, bus.i_wb_data};
            rsp_valid_reg <= 1'b1;
            if (autoinc_reg) begin
              addr_reg <= addr_reg + ADDR_INC;  // wraps modulo 2^32
            end
            state_reg <= RSP;
          end else if (timeout_hit) begin
            wb_cyc_reg    <= 1'b0;
            wb_we_reg     <= 1'b0;
            rsp_data_reg  <= {RSP_SPECIAL, wb_addr_reg};
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end

        RSP: begin
          // Response is held unchanged until consumed; ready stays low.
          if (bus.i_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready = cmd_ready_reg;
  assign bus.o_rsp_valid = rsp_valid_reg;
  assign bus.o_rsp_data  = rsp_data_reg;
  assign bus.o_wb_cyc    = wb_cyc_reg;
  assign bus.o_wb_stb    = wb_stb_reg;
  assign bus.o_wb_we     = wb_we_reg;
  assign bus.o_wb_addr   = wb_addr_reg;
  assign bus.o_wb_data   = wb_data_reg;
  assign bus.o_wb_sel    = wb_sel_reg;

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_sequencer
//
// Directed bench for wb_cmd_sequencer (TIMEOUT=16, ADDR_INC=1).  A table of
// command records (stimulus + hand-computed expected response, latency and
// Wishbone request fields) is played in order; reset-related corner cases
// are hand-written sequences.  Cycle 1 is the first cycle after the command
// was accepted; all outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_cmd_sequencer;

  localparam int NEV = 255;  // "never" for ack delay

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_sequencer_if bus ();

  wb_cmd_sequencer #(
    .TIMEOUT  (16),
    .ADDR_INC (32'd1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] pl;
    int          stall_n;   // stb cycles with stall=1
    int          ack_dly;   // WAIT cycles before the answer (NEV = none)
    int          mode;      // 0 ack, 1 err, 2 ack+err
    logic        junk;      // drive ack/err during stalled REQ cycles
    logic [31:0] rd;        // slave read data
    int          rdy_dly;   // cycles response is left unconsumed
    logic [1:0]  e_code;
    logic [31:0] e_pl;
    int          e_lat;
    int          e_stb;
    int          e_cyc;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [31:0] pl, int stall_n,
                              int ack_dly, int mode, logic junk, logic [31:0] rd,
                              int rdy_dly, logic [1:0] e_code, logic [31:0] e_pl,
                              int e_lat, int e_stb, int e_cyc, logic [31:0] e_addr,
                              logic e_we, logic [31:0] e_wd);
    vec_t v;
    v.op = op; v.pl = pl; v.stall_n = stall_n; v.ack_dly = ack_dly;
    v.mode = mode; v.junk = junk; v.rd = rd; v.rdy_dly = rdy_dly;
    v.e_code = e_code; v.e_pl = e_pl; v.e_lat = e_lat; v.e_stb = e_stb;
    v.e_cyc = e_cyc; v.e_addr = e_addr; v.e_we = e_we; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data  = '0;
    bus.i_rsp_ready = 1'b0;
    bus.i_wb_stall  = 1'b0;
    bus.i_wb_ack    = 1'b0;
    bus.i_wb_err    = 1'b0;
    bus.i_wb_data   = '0;
  endtask

  // Wait (bounded) for o_cmd_ready, then present one command for one cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] pl);
    int k = 0;
    while (bus.o_cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_before_cmd", {63'd0, bus.o_cmd_ready}, 64'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_data  = {op, pl};
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data  = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          stb_cnt = 0;
    int          cyc_cnt = 0;
    int          wait_cnt = 0;
    int          lat = 0;
    logic        got = 1'b0;
    logic        unstable = 1'b0;
    logic        hold_bad = 1'b0;
    logic [31:0] a_addr = '0;
    logic [31:0] a_wd = '0;
    logic        a_we = 1'b0;
    logic [3:0]  a_sel = '0;
    logic [33:0] r_data = '0;

    bus.i_wb_data = v.rd;
    issue(v.op, v.pl);
    for (int c = 1; c <= 200 && !got; c++) begin
      bus.i_wb_stall = 1'b0;
      bus.i_wb_ack   = 1'b0;
      bus.i_wb_err   = 1'b0;
      if (bus.o_wb_stb) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          a_addr = bus.o_wb_addr; a_wd = bus.o_wb_data;
          a_we = bus.o_wb_we; a_sel = bus.o_wb_sel;
        end else if (bus.o_wb_addr !== a_addr || bus.o_wb_data !== a_wd ||
                     bus.o_wb_we !== a_we) begin
          unstable = 1'b1;
        end
        if (stb_cnt <= v.stall_n) begin
          bus.i_wb_stall = 1'b1;
          bus.i_wb_ack   = v.junk;
          bus.i_wb_err   = v.junk;
        end
      end else if (bus.o_wb_cyc) begin
        if (wait_cnt == v.ack_dly) begin
          bus.i_wb_ack = (v.mode != 1);
          bus.i_wb_err = (v.mode != 0);
        end
        wait_cnt++;
      end
      if (bus.o_wb_cyc) cyc_cnt++;
      if (bus.o_rsp_valid) begin
        got = 1'b1;
        lat = c;
        r_data = bus.o_rsp_data;
        chk("cmd_ready_low_in_rsp", {63'd0, bus.o_cmd_ready}, 64'd0);
        chk("cyc_low_in_rsp", {63'd0, bus.o_wb_cyc}, 64'd0);
      end else begin
        @(negedge clk);
      end
    end
    bus.i_wb_stall = 1'b0;
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_err   = 1'b0;

    chk("rsp_seen", {63'd0, got}, 64'd1);
    if (got) begin
      for (int h = 0; h < v.rdy_dly; h++) begin
        @(negedge clk);
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== r_data ||
            bus.o_cmd_ready !== 1'b0)
          hold_bad = 1'b1;
      end
      chk("rsp_hold_stable", {63'd0, hold_bad}, 64'd0);
      bus.i_rsp_ready = 1'b1;
      @(negedge clk);
      bus.i_rsp_ready = 1'b0;
      chk("rsp_valid_after_pop", {63'd0, bus.o_rsp_valid}, 64'd0);
    end
    chk("rsp_code",    {62'd0, r_data[33:32]}, {62'd0, v.e_code});
    chk("rsp_payload", {32'd0, r_data[31:0]},  {32'd0, v.e_pl});
    chk("latency",     64'(lat),     64'(v.e_lat));
    chk("stb_cycles",  64'(stb_cnt), 64'(v.e_stb));
    chk("cyc_cycles",  64'(cyc_cnt), 64'(v.e_cyc));
    if (v.e_stb > 0) begin
      chk("wb_addr",   {32'd0, a_addr}, {32'd0, v.e_addr});
      chk("wb_we",     {63'd0, a_we},   {63'd0, v.e_we});
      chk("wb_data",   {32'd0, a_wd},   {32'd0, v.e_wd});
      chk("wb_sel",    {60'd0, a_sel},  64'hF);
      chk("req_stable", {63'd0, unstable}, 64'd0);
    end
    $display("vec %0d op=%0d pl=0x%08h -> rsp=%0d/0x%08h lat=%0d stb=%0d cyc=%0d addr=0x%08h",
             idx, v.op, v.pl, r_data[33:32], r_data[31:0], lat, stb_cnt, cyc_cnt, a_addr);
  endtask

  vec_t tbl [24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //           op pl            stl ack mode j rd            rdy code pl            lat stb cyc addr          we wd
    tbl[0]  = mk(2, 32'h100,       0, 0,  0, 0, 0,             0, 2, 32'h100,       1,  0,  0,  0,            0, 0);
    tbl[1]  = mk(1, 32'hDEADBEEF,  0, 0,  0, 0, 0,             0, 1, 32'hDEADBEEF,  3,  1,  2,  32'h100,      1, 32'hDEADBEEF);
    tbl[2]  = mk(3, 32'h1,         0, 0,  0, 0, 0,             0, 3, 32'h1,         1,  0,  0,  0,            0, 0);
    tbl[3]  = mk(2, 32'h10,        0, 0,  0, 0, 0,             0, 2, 32'h10,        1,  0,  0,  0,            0, 0);
    tbl[4]  = mk(0, 32'h0,         0, 0,  0, 0, 32'hA5A50010,  0, 0, 32'hA5A50010,  3,  1,  2,  32'h10,       0, 0);
    tbl[5]  = mk(0, 32'h5555AAAA,  0, 0,  0, 0, 32'h11111111,  0, 0, 32'h11111111,  3,  1,  2,  32'h11,       0, 0);
    tbl[6]  = mk(0, 32'h0,         0, 0,  0, 0, 32'h22222222,  0, 0, 32'h22222222,  3,  1,  2,  32'h12,       0, 0);
    tbl[7]  = mk(0, 32'h0,         5, 0,  0, 1, 32'h33333333,  0, 0, 32'h33333333,  8,  6,  7,  32'h13,       0, 0);
    tbl[8]  = mk(0, 32'h0,         0, 3,  0, 0, 32'h44444444, 10, 0, 32'h44444444,  6,  1,  5,  32'h14,       0, 0);
    tbl[9]  = mk(0, 32'h0,         0, NEV,0, 0, 32'h0,         0, 3, 32'h15,       17,  1, 16,  32'h15,       0, 0);
    tbl[10] = mk(0, 32'h0,         0, 0,  0, 0, 32'h55,        0, 0, 32'h55,        3,  1,  2,  32'h15,       0, 0);
    tbl[11] = mk(1, 32'h12345678,  0, 0,  1, 0, 32'h0,         0, 3, 32'h16,        3,  1,  2,  32'h16,       1, 32'h12345678);
    tbl[12] = mk(0, 32'h0,         0, 0,  2, 0, 32'h66,        0, 3, 32'h16,        3,  1,  2,  32'h16,       0, 0);
    tbl[13] = mk(2, 32'hFFFFFFFF,  0, 0,  0, 0, 0,             0, 2, 32'hFFFFFFFF,  1,  0,  0,  0,            0, 0);
    tbl[14] = mk(0, 32'h0,         0, 0,  0, 0, 32'h77,        0, 0, 32'h77,        3,  1,  2,  32'hFFFFFFFF, 0, 0);
    tbl[15] = mk(0, 32'h0,         0, 0,  0, 0, 32'h88,        0, 0, 32'h88,        3,  1,  2,  32'h0,        0, 0);
    tbl[16] = mk(3, 32'h2,         0, 0,  0, 0, 0,             0, 3, 32'h2,         1,  0,  0,  0,            0, 0);
    tbl[17] = mk(0, 32'h0,         0, 0,  0, 0, 32'h99,        0, 0, 32'h99,        3,  1,  2,  32'h0,        0, 0);
    tbl[18] = mk(0, 32'h0,         0, 0,  0, 0, 32'hAA,        0, 0, 32'hAA,        3,  1,  2,  32'h0,        0, 0);
    tbl[19] = mk(3, 32'h3,         0, 0,  0, 0, 0,             0, 3, 32'h3,         1,  0,  0,  0,            0, 0);
    tbl[20] = mk(1, 32'hCAFEF00D,  2, 0,  0, 0, 0,             0, 1, 32'hCAFEF00D,  5,  3,  4,  32'h0,        1, 32'hCAFEF00D);
    tbl[21] = mk(0, 32'h0,         0, 0,  0, 0, 32'hBB,        0, 0, 32'hBB,        3,  1,  2,  32'h1,        0, 0);
    tbl[22] = mk(0, 32'h0,       100, 0,  0, 0, 32'h0,         0, 3, 32'h2,        17, 16, 16,  32'h2,        0, 0);
    tbl[23] = mk(0, 32'h0,         0, 0,  0, 0, 32'hCC,        0, 0, 32'hCC,        3,  1,  2,  32'h2,        0, 0);

    // Reset state
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {63'd0, bus.o_cmd_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd0);
    chk("rst_rsp_data",  {30'd0, bus.o_rsp_data}, 64'd0);
    chk("rst_wb_ctrl",   {61'd0, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we}, 64'd0);
    chk("rst_wb_addr_data", {bus.o_wb_addr, bus.o_wb_data}, 64'd0);
    chk("rst_wb_sel",    {60'd0, bus.o_wb_sel}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, bus.o_cmd_ready}, 64'd1);
    $display("reset: cmd_ready=%0d after release", bus.o_cmd_ready);

    for (int i = 0; i < 24; i++) run_vec(i, tbl[i]);

    // Reset while a response is being held: it must be discarded.
    issue(2'd2, 32'h40);
    chk("held_rsp_valid", {63'd0, bus.o_rsp_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_drops_rsp", {63'd0, bus.o_rsp_valid}, 64'd0);
    @(negedge clk);
    chk("ready_after_rsp_rst", {63'd0, bus.o_cmd_ready}, 64'd1);
    $display("reset during RSP: rsp_valid=%0d cmd_ready=%0d", bus.o_rsp_valid, bus.o_cmd_ready);

    // Reset pulse during WAIT: cyc drops on the next edge, no response.
    bus.i_wb_data = 32'hEE;
    issue(2'd0, 32'h0);                 // now in cycle 1 (REQ)
    chk("seq_req_stb", {63'd0, bus.o_wb_stb}, 64'd1);
    @(negedge clk);                     // cycle 2 (WAIT)
    chk("seq_wait_cyc_stb", {62'd0, bus.o_wb_cyc, bus.o_wb_stb}, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_cyc", {62'd0, bus.o_wb_cyc, bus.o_wb_stb}, 64'd0);
    chk("rst_wait_ready", {63'd0, bus.o_cmd_ready}, 64'd0);
    begin
      logic saw_rsp = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (bus.o_rsp_valid !== 1'b0) saw_rsp = 1'b1;
      end
      chk("no_rsp_after_rst", {63'd0, saw_rsp}, 64'd0);
    end
    chk("ready_after_wait_rst", {63'd0, bus.o_cmd_ready}, 64'd1);
    $display("reset during WAIT: cyc=%0d rsp_valid=%0d", bus.o_wb_cyc, bus.o_rsp_valid);

    // Address and autoinc were cleared by reset: two reads both hit 0.
    run_vec(24, mk(0, 32'h0, 0, 0, 0, 0, 32'hD1, 0, 0, 32'hD1, 3, 1, 2, 32'h0, 0, 0));
    run_vec(25, mk(0, 32'h0, 0, 0, 0, 0, 32'hD2, 0, 0, 32'hD2, 3, 1, 2, 32'h0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
